// File: rtl/zle_enc_p.sv
// Zero run-length encoder: collapses runs of zero words into run tokens, passes
// literals through, forwards EOS tokens, with a registered stall-safe output slot.
module zle_enc_p #(
  parameter int W       = 8,
  parameter int MAX_RUN = 16
) (
  input  logic         clock,
  input  logic         reset,
  input  logic [W-1:0] i_d,
  input  logic         i_e,
  input  logic         i_v,
  output logic         i_b,
  output logic [W-1:0] o_d,
  output logic         o_z,
  output logic         o_e,
  output logic         o_v,
  input  logic         o_b
);

  localparam int CW = $clog2(MAX_RUN + 1);
  localparam logic [CW-1:0] ONE  = CW'(1);
  localparam logic [CW-1:0] LAST = CW'(MAX_RUN - 1);

  typedef enum logic [1:0] {LIT, RUN, P_LIT, P_EOS} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [W-1:0]  pend_q, pend_d;
  logic [W-1:0]  od_q, od_d;
  logic          oz_q, oz_d;
  logic          oe_q, oe_d;
  logic          ov_q, ov_d;
  logic          slot_free;
  logic          acc;

  // Zero-extend (or trim) a count to the output word width.
  function automatic logic [W-1:0] run_word(input logic [CW-1:0] n);
    logic [W+CW-1:0] ext;
    ext = {{W{1'b0}}, n};
    return ext[W-1:0];
  endfunction

  assign slot_free = !ov_q || !o_b;
  assign i_b       = !reset || !slot_free || (state_q == P_LIT) || (state_q == P_EOS);
  assign acc       = i_v && !i_b;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pend_d  = pend_q;
    od_d    = od_q;
    oz_d    = oz_q;
    oe_d    = oe_q;
    ov_d    = ov_q && o_b;
    case (state_q)
      LIT: begin
        if (acc) begin
          if (i_e) begin
            od_d = '0; oz_d = 1'b0; oe_d = 1'b1; ov_d = 1'b1;
          end else if (i_d == '0) begin
            cnt_d   = ONE;
            state_d = RUN;
          end else begin
            od_d = i_d; oz_d = 1'b0; oe_d = 1'b0; ov_d = 1'b1;
          end
        end
      end
      RUN: begin
        if (acc) begin
          if (!i_e && i_d == '0 && cnt_q != LAST) begin
            cnt_d = cnt_q + ONE;
          end else begin
            // Every other accepted token closes the current run.
            od_d  = (!i_e && i_d == '0) ? run_word(LAST) : run_word(cnt_q - ONE);
            oz_d  = 1'b1;
            oe_d  = 1'b0;
            ov_d  = 1'b1;
            cnt_d = '0;
            if (i_e) begin
              state_d = P_EOS;
            end else if (i_d == '0) begin
              state_d = LIT;
            end else begin
              pend_d  = i_d;
              state_d = P_LIT;
            end
          end
        end
      end
      P_LIT: begin
        if (slot_free) begin
          od_d = pend_q; oz_d = 1'b0; oe_d = 1'b0; ov_d = 1'b1;
          state_d = LIT;
        end
      end
      P_EOS: begin
        if (slot_free) begin
          od_d = '0; oz_d = 1'b0; oe_d = 1'b1; ov_d = 1'b1;
          state_d = LIT;
        end
      end
      default: state_d = LIT;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= LIT;
      cnt_q   <= '0;
      pend_q  <= '0;
      od_q    <= '0;
      oz_q    <= 1'b0;
      oe_q    <= 1'b0;
      ov_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
      od_q    <= od_d;
      oz_q    <= oz_d;
      oe_q    <= oe_d;
      ov_q    <= ov_d;
    end
  end

  assign o_d = od_q;
  assign o_z = oz_q;
  assign o_e = oe_q;
  assign o_v = ov_q;

endmodule

// File: tb/tb_zle_enc_p.sv
// Bench for zle_enc_p: directed scenarios plus a random handshake run, with
// expected tokens queued as stimulus is driven and popped as the DUT emits them.
module tb_zle_enc_p;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [7:0] a_id, a_od;
  logic       a_ie, a_iv, a_ib, a_oz, a_oe, a_ov, a_ob;
  logic [3:0] b_id, b_od;
  logic       b_ie, b_iv, b_ib, b_oz, b_oe, b_ov, b_ob;

  int checks = 0;
  int errors = 0;
  logic [31:0] qa[$];
  logic [31:0] qb[$];
  int mcnt = 0;
  bit rnd_en = 1'b0;

  zle_enc_p #(.W(8), .MAX_RUN(16)) dut_a (
    .clock(clk), .reset(rst_n),
    .i_d(a_id), .i_e(a_ie), .i_v(a_iv), .i_b(a_ib),
    .o_d(a_od), .o_z(a_oz), .o_e(a_oe), .o_v(a_ov), .o_b(a_ob)
  );

  zle_enc_p #(.W(4), .MAX_RUN(2)) dut_b (
    .clock(clk), .reset(rst_n),
    .i_d(b_id), .i_e(b_ie), .i_v(b_iv), .i_b(b_ib),
    .o_d(b_od), .o_z(b_oz), .o_e(b_oe), .o_v(b_ov), .o_b(b_ob)
  );

  function automatic logic [31:0] tk(input logic e, input logic z, input logic [7:0] d);
    return {22'b0, e, z, d};
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  // A transfer happens on the next rising edge whenever o_v & !o_b at the falling edge.
  always @(negedge clk) begin
    if (rst_n && a_ov && !a_ob) begin
      if (qa.size() == 0) chk("a_unexpected_token", tk(a_oe, a_oz, a_od), 32'hFFFF_FFFF);
      else chk("a_token", tk(a_oe, a_oz, a_od), qa.pop_front());
    end
    if (rst_n && b_ov && !b_ob) begin
      if (qb.size() == 0) chk("b_unexpected_token", tk(b_oe, b_oz, {4'b0, b_od}), 32'hFFFF_FFFF);
      else chk("b_token", tk(b_oe, b_oz, {4'b0, b_od}), qb.pop_front());
    end
  end

  always @(posedge clk) begin
    if (rnd_en) begin
      #1;
      a_ob = ($urandom_range(0, 2) == 0);
    end
  end

  task automatic send_a(input logic [7:0] d, input logic e);
    int n;
    bit acc;
    n = 0;
    acc = 1'b0;
    a_id = d; a_ie = e; a_iv = 1'b1;
    while (!acc && n < 200) begin
      @(negedge clk);
      acc = !a_ib;
      @(posedge clk);
      #1;
      n++;
    end
    if (!acc) chk("a_send_timeout", {31'b0, acc}, 32'd1);
  endtask

  task automatic send_b(input logic [3:0] d, input logic e);
    int n;
    bit acc;
    n = 0;
    acc = 1'b0;
    b_id = d; b_ie = e; b_iv = 1'b1;
    while (!acc && n < 200) begin
      @(negedge clk);
      acc = !b_ib;
      @(posedge clk);
      #1;
      n++;
    end
    if (!acc) chk("b_send_timeout", {31'b0, acc}, 32'd1);
  endtask

  task automatic idle_a(input int n);
    a_iv = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drain_a(input string tag);
    int n;
    n = 0;
    a_iv = 1'b0;
    while ((qa.size() != 0 || a_ov) && n < 300) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk(tag, 32'(qa.size()), 32'd0);
  endtask

  task automatic drain_b(input string tag);
    int n;
    n = 0;
    b_iv = 1'b0;
    while ((qb.size() != 0 || b_ov) && n < 300) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk(tag, 32'(qb.size()), 32'd0);
  endtask

  // Token-level reference: tracks only the pending zero count.
  task automatic model_a(input logic [7:0] d, input logic e);
    if (e) begin
      if (mcnt > 0) qa.push_back(tk(1'b0, 1'b1, 8'(mcnt - 1)));
      qa.push_back(tk(1'b1, 1'b0, 8'd0));
      mcnt = 0;
    end else if (d == 8'd0) begin
      mcnt++;
      if (mcnt == 16) begin
        qa.push_back(tk(1'b0, 1'b1, 8'd15));
        mcnt = 0;
      end
    end else begin
      if (mcnt > 0) qa.push_back(tk(1'b0, 1'b1, 8'(mcnt - 1)));
      qa.push_back(tk(1'b0, 1'b0, d));
      mcnt = 0;
    end
  endtask

  initial begin
    logic [31:0] held;
    logic [7:0]  rd;
    logic        re;
    int          r;
    a_id = '0; a_ie = 1'b0; a_iv = 1'b0; a_ob = 1'b0;
    b_id = '0; b_ie = 1'b0; b_iv = 1'b0; b_ob = 1'b0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_o_v", 32'(a_ov), 32'd0);
    chk("rst_o_d", 32'(a_od), 32'd0);
    chk("rst_o_z", 32'(a_oz), 32'd0);
    chk("rst_o_e", 32'(a_oe), 32'd0);
    chk("rst_i_b", 32'(a_ib), 32'd1);
    chk("rst_b_i_b", 32'(b_ib), 32'd1);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("idle_i_b", 32'(a_ib), 32'd0);

    // 5,0,0,0,7 back to back
    qa.push_back(tk(1'b0, 1'b0, 8'd5));
    qa.push_back(tk(1'b0, 1'b1, 8'd2));
    qa.push_back(tk(1'b0, 1'b0, 8'd7));
    send_a(8'd5, 1'b0);
    chk("t1_latency_v", 32'(a_ov), 32'd1);
    send_a(8'd0, 1'b0);
    send_a(8'd0, 1'b0);
    send_a(8'd0, 1'b0);
    send_a(8'd7, 1'b0);
    a_iv = 1'b0;
    chk("t1_i_b_plit", 32'(a_ib), 32'd1);
    @(posedge clk);
    #1;
    chk("t1_i_b_after", 32'(a_ib), 32'd0);
    drain_a("t1_drain");

    // 16 zeros then 3
    qa.push_back(tk(1'b0, 1'b1, 8'd15));
    qa.push_back(tk(1'b0, 1'b0, 8'd3));
    repeat (16) send_a(8'd0, 1'b0);
    chk("t2_run_at_16th", {a_ov, 31'b0} | tk(a_oe, a_oz, a_od), 32'h8000_010F);
    send_a(8'd3, 1'b0);
    drain_a("t2_drain");

    // i_v gap while in RUN keeps the count
    qa.push_back(tk(1'b0, 1'b1, 8'd4));
    qa.push_back(tk(1'b0, 1'b0, 8'd5));
    repeat (4) send_a(8'd0, 1'b0);
    idle_a(10);
    chk("gap_no_output", 32'(a_ov), 32'd0);
    send_a(8'd0, 1'b0);
    send_a(8'd5, 1'b0);
    drain_a("gap_drain");

    // 17 zeros, EOS, then 4
    qa.push_back(tk(1'b0, 1'b1, 8'd15));
    qa.push_back(tk(1'b0, 1'b1, 8'd0));
    qa.push_back(tk(1'b1, 1'b0, 8'd0));
    qa.push_back(tk(1'b0, 1'b0, 8'd4));
    repeat (17) send_a(8'd0, 1'b0);
    send_a(8'd0, 1'b1);
    send_a(8'd4, 1'b0);
    drain_a("t3_drain");

    // Output stall for 5 cycles
    qa.push_back(tk(1'b0, 1'b0, 8'h33));
    qa.push_back(tk(1'b0, 1'b0, 8'h44));
    send_a(8'h33, 1'b0);
    a_ob = 1'b1;
    a_id = 8'h44;
    held = tk(a_oe, a_oz, a_od);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("t4_stall_o_v", 32'(a_ov), 32'd1);
      chk("t4_stall_tok", tk(a_oe, a_oz, a_od), held);
      chk("t4_stall_i_b", 32'(a_ib), 32'd1);
      @(posedge clk);
      #1;
    end
    a_ob = 1'b0;
    send_a(8'h44, 1'b0);
    drain_a("t4_drain");

    // Reset with a token stuck in the slot and a pending literal
    repeat (5) send_a(8'd0, 1'b0);
    a_ob = 1'b1;
    send_a(8'd6, 1'b0);
    a_iv = 1'b0;
    chk("t5_pre_o_v", 32'(a_ov), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("t5_rst_o_v", 32'(a_ov), 32'd0);
    chk("t5_rst_i_b", 32'(a_ib), 32'd1);
    qa.delete();
    a_ob = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    qa.push_back(tk(1'b0, 1'b0, 8'd4));
    send_a(8'd4, 1'b0);
    drain_a("t5_drain");

    // Reset mid-run with cnt=5
    repeat (5) send_a(8'd0, 1'b0);
    a_iv = 1'b0;
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    qa.push_back(tk(1'b0, 1'b0, 8'd4));
    send_a(8'd4, 1'b0);
    drain_a("t5b_drain");

    // Random i_v/o_b against the token model
    mcnt = 0;
    rnd_en = 1'b1;
    for (int k = 0; k < 10000; k++) begin
      r = $urandom_range(0, 9);
      re = (r == 6);
      rd = (r >= 7) ? 8'($urandom_range(1, 255)) : 8'd0;
      send_a(rd, re);
      model_a(rd, re);
      if ($urandom_range(0, 3) == 0) idle_a($urandom_range(1, 3));
    end
    send_a(8'd0, 1'b1);
    model_a(8'd0, 1'b1);
    a_iv = 1'b0;
    rnd_en = 1'b0;
    @(posedge clk);
    #2;
    a_ob = 1'b0;
    drain_a("rand_drain");

    // W=4, MAX_RUN=2: 0,0,0,9,EOS
    qb.push_back(tk(1'b0, 1'b1, 8'd1));
    qb.push_back(tk(1'b0, 1'b1, 8'd0));
    qb.push_back(tk(1'b0, 1'b0, 8'd9));
    qb.push_back(tk(1'b1, 1'b0, 8'd0));
    send_b(4'd0, 1'b0);
    send_b(4'd0, 1'b0);
    send_b(4'd0, 1'b0);
    send_b(4'd9, 1'b0);
    send_b(4'd0, 1'b1);
    drain_b("t6_drain");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
